// File: rtl/mux_2to1.sv
// Two-input wormhole flit multiplexer with a registered output stage.
// A HEAD flit locks the mux to its port until that port's TAIL is forwarded.
module mux_2to1 #(
    parameter int DATAW = 36,
    parameter int VCHW  = 2,
    parameter int PORTW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata_0,
    input  logic             ivalid_0,
    input  logic [VCHW-1:0]  ivch_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic             ivalid_1,
    input  logic [VCHW-1:0]  ivch_1,
    input  logic [PORTW-1:0] sel,
    output logic [DATAW-1:0] odata,
    output logic             ovalid,
    output logic [VCHW-1:0]  ovch,
    output logic             obusy
);

    typedef enum logic [1:0] {
        FLIT_NONE = 2'b00,
        FLIT_HEAD = 2'b01,
        FLIT_DATA = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    logic             locked;
    logic             lock_port;
    logic             locked_next;
    logic             lock_port_next;
    logic             grant;
    logic             grant_port;
    logic [DATAW-1:0] grant_data;
    logic             grant_valid;
    logic [VCHW-1:0]  grant_vch;
    logic             forward;
    flit_type_e       grant_type;

    // Only the two low select bits name real ports on this mux.
    generate
        if (PORTW > 2) begin : g_spare_sel
            logic unused_sel;
            assign unused_sel = ^sel[PORTW-1:2];
        end
    endgenerate

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
        if (locked) begin
            grant      = 1'b1;
            grant_port = lock_port;
        end else if (sel[0]) begin
            grant      = 1'b1;
            grant_port = 1'b0;
        end else if (sel[1]) begin
            grant      = 1'b1;
            grant_port = 1'b1;
        end
    end

    always_comb begin
        grant_data  = grant_port ? idata_1  : idata_0;
        grant_valid = grant_port ? ivalid_1 : ivalid_0;
        grant_vch   = grant_port ? ivch_1   : ivch_0;
        grant_type  = flit_type_e'(grant_data[DATAW-1:DATAW-2]);
        forward     = grant && grant_valid;
    end

    // HEAD while locked and TAIL/DATA while unlocked pass through without touching the lock.
    always_comb begin
        locked_next    = locked;
        lock_port_next = lock_port;
        if (forward) begin
            if (!locked && grant_type == FLIT_HEAD) begin
                locked_next    = 1'b1;
                lock_port_next = grant_port;
            end else if (locked && grant_type == FLIT_TAIL) begin
                locked_next = 1'b0;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            odata     <= '0;
            ovalid    <= 1'b0;
            ovch      <= '0;
            locked    <= 1'b0;
            lock_port <= 1'b0;
        end else begin
            odata     <= forward ? grant_data : '0;
            ovalid    <= forward;
            ovch      <= forward ? grant_vch : '0;
            locked    <= locked_next;
            lock_port <= lock_port_next;
        end
    end

    assign obusy = locked;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed, table-driven bench for mux_2to1: each record is one cycle of
// stimulus plus the output values expected right after that cycle's edge.
module tb_mux_2to1;

    localparam int DATAW = 36;
    localparam int VCHW  = 2;
    localparam int PORTW = 5;

    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_DATA = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef struct {
        logic             rst;
        logic [PORTW-1:0] sel;
        logic             v0;
        logic [VCHW-1:0]  c0;
        logic [DATAW-1:0] d0;
        logic             v1;
        logic [VCHW-1:0]  c1;
        logic [DATAW-1:0] d1;
        logic [DATAW-1:0] e_data;
        logic             e_valid;
        logic [VCHW-1:0]  e_vch;
        logic             e_busy;
    } vec_t;

    logic             clk;
    logic             rst;
    logic [DATAW-1:0] idata_0;
    logic             ivalid_0;
    logic [VCHW-1:0]  ivch_0;
    logic [DATAW-1:0] idata_1;
    logic             ivalid_1;
    logic [VCHW-1:0]  ivch_1;
    logic [PORTW-1:0] sel;
    logic [DATAW-1:0] odata;
    logic             ovalid;
    logic [VCHW-1:0]  ovch;
    logic             obusy;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    mux_2to1 #(.DATAW(DATAW), .VCHW(VCHW), .PORTW(PORTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch),
        .obusy    (obusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATAW-1:0] flit(input logic [1:0] t, input logic [33:0] p);
        return {t, p};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [PORTW-1:0] s,
                       input logic v0, input logic [VCHW-1:0] c0, input logic [DATAW-1:0] d0,
                       input logic v1, input logic [VCHW-1:0] c1, input logic [DATAW-1:0] d1,
                       input logic [DATAW-1:0] ed, input logic ev, input logic [VCHW-1:0] ec,
                       input logic eb);
        vec_t v;
        v.rst = r;  v.sel = s;
        v.v0 = v0;  v.c0 = c0;  v.d0 = d0;
        v.v1 = v1;  v.c1 = c1;  v.d1 = d1;
        v.e_data = ed;  v.e_valid = ev;  v.e_vch = ec;  v.e_busy = eb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [PORTW-1:0] s,
                         input logic v0, input logic [VCHW-1:0] c0, input logic [DATAW-1:0] d0,
                         input logic v1, input logic [VCHW-1:0] c1, input logic [DATAW-1:0] d1);
        rst = r;  sel = s;
        ivalid_0 = v0;  ivch_0 = c0;  idata_0 = d0;
        ivalid_1 = v1;  ivch_1 = c1;  idata_1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [DATAW-1:0] ed, input logic ev,
                             input logic [VCHW-1:0] ec, input logic eb);
        check({tag, ".odata"},  64'(odata),  64'(ed));
        check({tag, ".ovalid"}, 64'(ovalid), 64'(ev));
        check({tag, ".ovch"},   64'(ovch),   64'(ec));
        check({tag, ".obusy"},  64'(obusy),  64'(eb));
    endtask

    initial begin
        logic [DATAW-1:0] rnd;
        logic [DATAW-1:0] d;
        logic [DATAW-1:0] pat [9];

        rst = 1'b1;  sel = '0;
        idata_0 = '0;  ivalid_0 = 1'b0;  ivch_0 = '0;
        idata_1 = '0;  ivalid_1 = 1'b0;  ivch_1 = '0;

        // Reset held two cycles with both ports offering valid HEADs.
        for (int i = 0; i < 2; i++)
            add(1, 5'b00011, 1, 2'd1, flit(T_HEAD, 34'h1), 1, 2'd2, flit(T_HEAD, 34'h2), '0, 0, '0, 0);

        // Port-1 packet of HEAD, 20 DATA, TAIL on VC 2 while port 0 sends noise.
        for (int i = 0; i < 22; i++) begin
            rnd = {$urandom(), 4'($urandom())};
            if (i == 0)       d = flit(T_HEAD, 34'h100);
            else if (i == 21) d = flit(T_TAIL, 34'h3FF);
            else              d = flit(T_DATA, 34'h200 + 34'(i));
            add(0, 5'b00010, 1, 2'($urandom_range(0, 3)), rnd, 1, 2'd2, d, d, 1, 2'd2, (i != 21));
        end

        // Seven idle cycles after the TAIL: no stale data may leak.
        for (int i = 0; i < 7; i++)
            add(0, 5'b00010, 0, 2'd1, flit(T_DATA, 34'h777), 0, 2'd3, flit(T_DATA, 34'h888), '0, 0, '0, 0);

        // Select moves to port 0 while port 1 holds the lock.
        add(0, 5'b00010, 1, 2'd1, flit(T_DATA, 34'hA00), 1, 2'd3, flit(T_HEAD, 34'h500), flit(T_HEAD, 34'h500), 1, 2'd3, 1);
        add(0, 5'b00010, 1, 2'd1, flit(T_DATA, 34'hA01), 1, 2'd3, flit(T_DATA, 34'h501), flit(T_DATA, 34'h501), 1, 2'd3, 1);
        add(0, 5'b00001, 1, 2'd1, flit(T_DATA, 34'hA02), 1, 2'd3, flit(T_DATA, 34'h502), flit(T_DATA, 34'h502), 1, 2'd3, 1);
        add(0, 5'b00001, 1, 2'd1, flit(T_DATA, 34'hA03), 0, 2'd3, flit(T_DATA, 34'h5FF), '0, 0, '0, 1);
        add(0, 5'b00001, 1, 2'd1, flit(T_DATA, 34'hA04), 1, 2'd3, flit(T_TAIL, 34'h503), flit(T_TAIL, 34'h503), 1, 2'd3, 0);
        add(0, 5'b00001, 1, 2'd1, flit(T_DATA, 34'hA05), 1, 2'd3, flit(T_DATA, 34'h504), flit(T_DATA, 34'hA05), 1, 2'd1, 0);
        add(0, 5'b00001, 1, 2'd1, flit(T_DATA, 34'hA06), 1, 2'd3, flit(T_DATA, 34'h505), flit(T_DATA, 34'hA06), 1, 2'd1, 0);

        // Port-0 priority, HEAD inside a locked packet, then no-grant selects.
        add(0, 5'b00011, 1, 2'd0, flit(T_HEAD, 34'hB00), 1, 2'd2, flit(T_HEAD, 34'hC00), flit(T_HEAD, 34'hB00), 1, 2'd0, 1);
        add(0, 5'b00010, 1, 2'd0, flit(T_HEAD, 34'hB01), 1, 2'd2, flit(T_DATA, 34'hC01), flit(T_HEAD, 34'hB01), 1, 2'd0, 1);
        add(0, 5'b00010, 1, 2'd0, flit(T_DATA, 34'hB02), 1, 2'd2, flit(T_DATA, 34'hC02), flit(T_DATA, 34'hB02), 1, 2'd0, 1);
        add(0, 5'b00010, 1, 2'd0, flit(T_TAIL, 34'hB03), 1, 2'd2, flit(T_DATA, 34'hC03), flit(T_TAIL, 34'hB03), 1, 2'd0, 0);
        add(0, 5'b00000, 1, 2'd1, flit(T_HEAD, 34'hB04), 1, 2'd2, flit(T_HEAD, 34'hC04), '0, 0, '0, 0);
        add(0, 5'b11100, 1, 2'd1, flit(T_HEAD, 34'hB05), 1, 2'd2, flit(T_HEAD, 34'hC05), '0, 0, '0, 0);
        add(0, 5'b11110, 1, 2'd3, flit(T_HEAD, 34'hB06), 1, 2'd1, flit(T_DATA, 34'hC06), flit(T_DATA, 34'hC06), 1, 2'd1, 0);
        add(0, 5'b00010, 0, 2'd3, flit(T_HEAD, 34'hB07), 1, 2'd1, flit(T_TAIL, 34'hC07), flit(T_TAIL, 34'hC07), 1, 2'd1, 0);
        add(0, 5'b00001, 1, 2'd3, flit(T_DATA, 34'hB08), 1, 2'd1, flit(T_DATA, 34'hC08), flit(T_DATA, 34'hB08), 1, 2'd3, 0);

        // Back-to-back packets on port 1 with no bubble between TAIL and HEAD.
        add(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_HEAD, 34'hD00), flit(T_HEAD, 34'hD00), 1, 2'd2, 1);
        add(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_TAIL, 34'hD01), flit(T_TAIL, 34'hD01), 1, 2'd2, 0);
        add(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_HEAD, 34'hD02), flit(T_HEAD, 34'hD02), 1, 2'd2, 1);
        add(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_DATA, 34'hD03), flit(T_DATA, 34'hD03), 1, 2'd2, 1);
        add(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_TAIL, 34'hD04), flit(T_TAIL, 34'hD04), 1, 2'd2, 0);

        // Bit-exact payload patterns (none carries the HEAD code, so no lock).
        pat = '{36'h000000000, 36'hFF0000000, 36'hFFFF00000, 36'hFFFFFF000, 36'hFFFFFFFF0,
                36'h0FFFFFFFF, 36'h000FFFFFF, 36'h00000FFFF, 36'h0000000FF};
        for (int i = 0; i < 9; i++)
            add(0, 5'b00010, 1, 2'd0, ~pat[i], 1, 2'd1, pat[i], pat[i], 1, 2'd1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].sel, vecs[i].v0, vecs[i].c0, vecs[i].d0,
                  vecs[i].v1, vecs[i].c1, vecs[i].d1);
            check_out($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid,
                      vecs[i].e_vch, vecs[i].e_busy);
        end

        // Reset mid-packet drops the lock; sel governs straight after release.
        drive(0, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_HEAD, 34'hE00));
        check_out("rst_mid.head", flit(T_HEAD, 34'hE00), 1, 2'd2, 1);
        drive(1, 5'b00010, 0, 2'd0, '0, 1, 2'd2, flit(T_DATA, 34'hE01));
        check_out("rst_mid.reset", '0, 0, '0, 0);
        drive(0, 5'b00001, 1, 2'd3, flit(T_DATA, 34'hE10), 1, 2'd2, flit(T_DATA, 34'hE02));
        check_out("rst_mid.after", flit(T_DATA, 34'hE10), 1, 2'd3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
